// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Parametrised serial pattern detector. Shifts in one bit per en cycle and
//   flags when the last N bits equal a runtime-loadable pattern. The output can
//   be Mealy (combinational, same cycle as the completing bit) or Moore
//   (registered, one cycle later). Overlapping matches are optional, and a
//   saturating match counter is included.
//
// Parameters
//   N           pattern length in bits (N >= 2)
//   CNT_W       match counter width
//   DEFAULT_PAT pattern loaded at reset (first-received bit is the MSB)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   en         m carries a valid serial bit this cycle
//   m          serial data bit
//   mode       0 = Mealy output, 1 = Moore output
//   overlap    1 = matches may share bits, 0 = history flushed after a match
//   pat_load   load pat_in as the new pattern (wins over en)
//   pat_in     new pattern, first-received bit is the MSB
//   cnt_clr    synchronous clear of match_cnt (wins over a hit)
//   s          match flag
//   match_cnt  saturating match count
module seq_detector_param #(
  parameter int             N           = 3,
  parameter int             CNT_W       = 8,
  parameter logic [N-1:0]   DEFAULT_PAT = N'(3'b101)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             m,
  input  logic             mode,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             s,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            FW        = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  // One bit short of full is enough: the incoming m supplies the last bit.
  localparam logic [FW-1:0] FILL_ARM  = FW'(N - 1);

  logic [N-1:0]     pat_r, pat_next;
  logic [N-1:0]     hist, hist_next;
  logic [FW-1:0]    fill, fill_next;
  logic             moore_q, moore_next;
  logic [CNT_W-1:0] cnt_r, cnt_next;

  logic [N-1:0]     cand;
  logic             hit;

  // Candidate window: the stored history with the current bit appended.
  assign cand = {hist[N-2:0], m};
  assign hit  = en & ~pat_load & (fill >= FILL_ARM) & (cand == pat_r);

  always_comb begin
    pat_next   = pat_r;
    hist_next  = hist;
    fill_next  = fill;
    moore_next = moore_q;
    cnt_next   = cnt_r;

    if (pat_load) begin
      // A new pattern invalidates the history; any bit this cycle is dropped.
      pat_next   = pat_in;
      hist_next  = '0;
      fill_next  = '0;
      moore_next = 1'b0;
    end else if (en) begin
      moore_next = hit;
      if (hit && !overlap) begin
        hist_next = '0;
        fill_next = '0;
      end else begin
        hist_next = cand;
        fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
      end
    end

    if (cnt_clr) begin
      cnt_next = '0;
    end else if (hit && (cnt_r != '1)) begin
      cnt_next = cnt_r + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r   <= DEFAULT_PAT;
      hist    <= '0;
      fill    <= '0;
      moore_q <= 1'b0;
      cnt_r   <= '0;
    end else begin
      pat_r   <= pat_next;
      hist    <= hist_next;
      fill    <= fill_next;
      moore_q <= moore_next;
      cnt_r   <= cnt_next;
    end
  end

  // moore_q is tracked in both modes so switching mode never loses state.
  // While rst is held fill is 0, which keeps hit (and thus s) low.
  assign s         = mode ? moore_q : hit;
  assign match_cnt = cnt_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param. Two instances share every input: one with
// an 8-bit counter and one with a 2-bit counter to exercise saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, m, mode, overlap, pat_load, cnt_clr;
  logic [2:0] pat_in;
  logic       s_a, s_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  seq_detector_param #(.N(3), .CNT_W(8), .DEFAULT_PAT(3'b101)) dut_a (
    .clk(clk), .rst(rst), .en(en), .m(m), .mode(mode), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .s(s_a), .match_cnt(cnt_a)
  );

  seq_detector_param #(.N(3), .CNT_W(2), .DEFAULT_PAT(3'b101)) dut_b (
    .clk(clk), .rst(rst), .en(en), .m(m), .mode(mode), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .s(s_b), .match_cnt(cnt_b)
  );

  typedef struct {
    string      name;
    logic       en, m, mode, ov, pl;
    logic [2:0] pi;
    logic       clr;
    logic       exp_s;
    logic [7:0] exp_c8;
    logic [1:0] exp_c2;
  } vec_t;

  typedef struct {
    string      name;
    logic       s;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input string nm, input logic e, input logic mm, input logic md,
                     input logic ov, input logic pl, input logic [2:0] pi,
                     input logic clr, input logic es, input int c8, input int c2);
    vec_t v;
    v.name = nm; v.en = e; v.m = mm; v.mode = md; v.ov = ov; v.pl = pl;
    v.pi = pi; v.clr = clr; v.exp_s = es; v.exp_c8 = 8'(c8); v.exp_c2 = 2'(c2);
    tbl.push_back(v);
  endtask

  task automatic push_exp(input string nm, input logic es, input logic [7:0] c8,
                          input logic [1:0] c2);
    exp_t x;
    x.name = nm; x.s = es; x.c8 = c8; x.c2 = c2;
    sb.push_back(x);
  endtask

  task automatic check_now();
    exp_t x;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    x = sb.pop_front();
    n_checks++;
    if (s_a !== x.s) begin
      n_fail++;
      $display("FAIL %s s(cnt8 inst): got %0b required %0b", x.name, s_a, x.s);
    end
    n_checks++;
    if (s_b !== x.s) begin
      n_fail++;
      $display("FAIL %s s(cnt2 inst): got %0b required %0b", x.name, s_b, x.s);
    end
    n_checks++;
    if (cnt_a !== x.c8) begin
      n_fail++;
      $display("FAIL %s match_cnt8: got %0d required %0d", x.name, cnt_a, x.c8);
    end
    n_checks++;
    if (cnt_b !== x.c2) begin
      n_fail++;
      $display("FAIL %s match_cnt2: got %0d required %0d", x.name, cnt_b, x.c2);
    end
    $display("%-14s en=%0b m=%0b mode=%0b ov=%0b pl=%0b clr=%0b -> s=%0b cnt8=%0d cnt2=%0d",
             x.name, en, m, mode, overlap, pat_load, cnt_clr, s_a, cnt_a, cnt_b);
  endtask

  // Drive one cycle's inputs just after a rising edge, check before the next.
  task automatic drive(input vec_t v);
    en = v.en; m = v.m; mode = v.mode; overlap = v.ov;
    pat_load = v.pl; pat_in = v.pi; cnt_clr = v.clr;
    push_exp(v.name, v.exp_s, v.exp_c8, v.exp_c2);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string nm, input logic e, input logic mm,
                      input logic es, input int c8, input int c2);
    vec_t v;
    v.name = nm; v.en = e; v.m = mm; v.mode = 1'b0; v.ov = 1'b1; v.pl = 1'b0;
    v.pi = 3'b000; v.clr = 1'b0; v.exp_s = es; v.exp_c8 = 8'(c8); v.exp_c2 = 2'(c2);
    drive(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0; m = 1'b0; mode = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 3'b000; cnt_clr = 1'b0;

    //   name           en m  md ov pl pi      clr s  c8 c2
    // Overlap Mealy: hits on bits 3 and 5.
    add("ovl_b1",       1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    add("ovl_b2",       1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    add("ovl_b3",       1, 1, 0, 1, 0, 3'b000, 0, 1, 0, 0);
    add("ovl_b4",       1, 0, 0, 1, 0, 3'b000, 0, 0, 1, 1);
    add("ovl_b5",       1, 1, 0, 1, 0, 3'b000, 0, 1, 1, 1);
    add("ovl_idle",     0, 0, 0, 1, 0, 3'b000, 0, 0, 2, 2);
    add("flush1",       0, 0, 0, 1, 1, 3'b101, 1, 0, 2, 2);
    // Non-overlap: history flushed after bit 3, next hit needs a fresh 1,0,1.
    add("nov_b1",       1, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    add("nov_b2",       1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    add("nov_b3",       1, 1, 0, 0, 0, 3'b000, 0, 1, 0, 0);
    add("nov_b4",       1, 0, 0, 0, 0, 3'b000, 0, 0, 1, 1);
    add("nov_b5",       1, 1, 0, 0, 0, 3'b000, 0, 0, 1, 1);
    add("nov_b6",       1, 1, 0, 0, 0, 3'b000, 0, 0, 1, 1);
    add("nov_b7",       1, 0, 0, 0, 0, 3'b000, 0, 0, 1, 1);
    add("nov_b8",       1, 1, 0, 0, 0, 3'b000, 0, 1, 1, 1);
    add("nov_idle",     0, 0, 0, 0, 0, 3'b000, 0, 0, 2, 2);
    add("flush2",       0, 0, 0, 1, 1, 3'b101, 1, 0, 2, 2);
    // Moore: s rises one edge after bit 3, holds while idle, mode switch is immediate.
    add("moo_b1",       1, 1, 1, 1, 0, 3'b000, 0, 0, 0, 0);
    add("moo_b2",       1, 0, 1, 1, 0, 3'b000, 0, 0, 0, 0);
    add("moo_b3",       1, 1, 1, 1, 0, 3'b000, 0, 0, 0, 0);
    add("moo_idle1",    0, 0, 1, 1, 0, 3'b000, 0, 1, 1, 1);
    add("moo_idle2",    0, 0, 0, 1, 0, 3'b000, 0, 0, 1, 1);
    add("moo_idle3",    0, 0, 1, 1, 0, 3'b000, 0, 1, 1, 1);
    add("moo_b4",       1, 0, 1, 1, 0, 3'b000, 0, 1, 1, 1);
    add("moo_after",    0, 0, 1, 1, 0, 3'b000, 0, 0, 1, 1);
    add("flush3",       0, 0, 1, 1, 1, 3'b101, 1, 0, 1, 1);
    // Runtime load: the bit in the load cycle would have completed 101.
    add("ld_b1",        1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    add("ld_b2",        1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    add("ld_load",      1, 1, 0, 1, 1, 3'b110, 0, 0, 0, 0);
    add("ld_c1",        1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    add("ld_c2",        1, 1, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    add("ld_c3",        1, 0, 0, 1, 0, 3'b000, 0, 1, 0, 0);
    add("ld_d1",        1, 1, 0, 1, 0, 3'b000, 0, 0, 1, 1);
    add("ld_d2",        1, 0, 0, 1, 0, 3'b000, 0, 0, 1, 1);
    add("ld_d3",        1, 1, 0, 1, 0, 3'b000, 0, 0, 1, 1);
    add("flush4",       0, 0, 0, 1, 1, 3'b101, 1, 0, 1, 1);
    // Counter: 5 hits, 2-bit counter saturates at 3; cnt_clr wins over a hit.
    for (int i = 1; i <= 11; i++) begin
      int hits_before;
      hits_before = (i >= 4) ? (i - 2) / 2 : 0;
      add($sformatf("cnt_b%0d", i), 1, 1'(i % 2), 0, 1, 0, 3'b000, 0,
          1'((i >= 3) && (i % 2 == 1)), hits_before, (hits_before > 3) ? 3 : hits_before);
    end
    add("cnt_b12",      1, 0, 0, 1, 0, 3'b000, 0, 0, 5, 3);
    add("cnt_clr_hit",  1, 1, 0, 1, 0, 3'b000, 1, 1, 5, 3);
    add("cnt_b14",      1, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    add("cnt_b15",      1, 1, 0, 1, 0, 3'b000, 0, 1, 0, 0);
    add("cnt_idle",     0, 0, 0, 1, 0, 3'b000, 0, 0, 1, 1);
    // Prepare for async reset: pattern 011, then stream 0,1.
    add("rs_load",      0, 0, 0, 1, 1, 3'b011, 0, 0, 1, 1);
    add("rs_b1",        1, 0, 0, 1, 0, 3'b000, 0, 0, 1, 1);
    add("rs_b2",        1, 1, 0, 1, 0, 3'b000, 0, 0, 1, 1);

    // Asynchronous reset takes effect with no clock edge.
    #2;
    rst = 1'b1;
    #1;
    push_exp("reset", 1'b0, 8'd0, 2'd0);
    check_now();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_exp("reset_rel", 1'b0, 8'd0, 2'd0);
    check_now();

    foreach (tbl[i]) drive(tbl[i]);

    // Completing bit of 011 raises Mealy s; an async reset mid-cycle drops it.
    en = 1'b1; m = 1'b1; mode = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; cnt_clr = 1'b0;
    #2;
    push_exp("rs_hit", 1'b1, 8'd1, 2'd1);
    check_now();
    rst = 1'b1;
    #1;
    push_exp("rs_async", 1'b0, 8'd0, 2'd0);
    check_now();
    rst = 1'b0;
    @(posedge clk);   // m=1 is taken as the first bit of fresh history
    #1;
    // Pattern is back to 101: 1 (already taken), 0, 1 hits.
    step("rs_c2", 1, 0, 0, 0, 0);
    step("rs_c3", 1, 1, 1, 0, 0);
    step("rs_idle", 0, 0, 0, 1, 1);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_left: got %0d pending, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
